// File: rtl/mac_product_accumulator.sv
// mac_product_accumulator: two-stage signed product accumulator with group handshake
// Ports: clk, rst (async, active-high); i_valid/i_ready/i_sign/i_exp/i_mant/i_last product beat in;
// o_valid/o_ready/o_sum/o_count group result out. Macro MAC_ACC_SAT_EN: saturate instead of wrap.
module mac_product_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        i_sign,
    input  logic [4:0]  i_exp,
    input  logic [9:0]  i_mant,
    input  logic        i_last,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [47:0] o_sum,
    output logic [7:0]  o_count
);
    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;
    state_t      state_q;
    logic        ready_q, valid_q, s1_vld_q, s1_last_q;
    logic [47:0] s1_term_q, acc_q, acc_d, mag, term_d;
    logic [48:0] sum;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept, clr;
`ifdef MAC_ACC_SAT_EN
    logic        sat_q, sat_d, ovf;
`endif
    always_comb begin
        accept = i_valid && ready_q;
        clr    = state_q == HOLD && o_ready;
        mag    = 48'(i_mant) << i_exp;
        term_d = i_sign ? -mag : mag;
        // one extra sign bit exposes signed overflow in bit 48 vs bit 47
        sum    = {acc_q[47], acc_q} + {s1_term_q[47], s1_term_q};
        cnt_d  = s1_vld_q && cnt_q != 8'hFF ? cnt_q + 8'd1 : cnt_q;
`ifdef MAC_ACC_SAT_EN
        ovf    = sum[48] != sum[47];
        sat_d  = sat_q || (s1_vld_q && ovf);
        // once on a rail the accumulator ignores further terms until cleared
        acc_d  = !s1_vld_q || sat_q ? acc_q :
                 ovf ? (sum[48] ? {1'b1, 47'd0} : {1'b0, {47{1'b1}}}) : sum[47:0];
`else
        acc_d  = s1_vld_q ? sum[47:0] : acc_q;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACC;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_term_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ACC: begin
                    state_q <= accept && i_last ? DRAIN : ACC;
                    ready_q <= !(accept && i_last);
                end
                DRAIN: if (s1_last_q) begin
                    state_q <= HOLD;
                    valid_q <= 1'b1;
                end
                HOLD: if (o_ready) begin
                    state_q <= ACC;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= ACC;
            endcase
            s1_vld_q <= accept;
            if (accept) begin
                s1_term_q <= term_d;
                s1_last_q <= i_last;
            end
            acc_q <= clr ? '0 : acc_d;
            cnt_q <= clr ? '0 : cnt_d;
        end
    end
`ifdef MAC_ACC_SAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= clr ? 1'b0 : sat_d;
    end
`endif
    assign i_ready = ready_q;
    assign o_valid = valid_q;
    assign o_sum   = acc_q;
    assign o_count = cnt_q;
endmodule

// File: tb/tb_mac_product_accumulator.sv
// tb_mac_product_accumulator: directed self-checking bench for mac_product_accumulator
module tb_mac_product_accumulator;
    logic        clk = 0, rst = 1;
    logic        i_valid = 0, i_sign = 0, i_last = 0, o_ready = 0;
    logic [4:0]  i_exp = 0;
    logic [9:0]  i_mant = 0;
    logic        i_ready, o_valid;
    logic [47:0] o_sum;
    logic [7:0]  o_count;
    int          checks = 0, errors = 0;
    logic [47:0] ovf_exp;
    mac_product_accumulator dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_sign(i_sign),
        .i_exp(i_exp), .i_mant(i_mant), .i_last(i_last), .o_valid(o_valid),
        .o_ready(o_ready), .o_sum(o_sum), .o_count(o_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic s, input logic [4:0] e, input logic [9:0] m, input logic l);
        int n = 0;
        i_valid = 1; i_sign = s; i_exp = e; i_mant = m; i_last = l;
        while (!i_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!i_ready) check("ready_timeout", 48'(i_ready), 48'd1);
        @(posedge clk); #1;
        i_valid = 0;
    endtask
    task automatic get_result(input string tag, input logic [47:0] es, input logic [7:0] ec);
        int n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_valid"}, 48'(o_valid), 48'd1);
        check({tag, "_sum"}, o_sum, es);
        check({tag, "_count"}, 48'(o_count), 48'(ec));
        o_ready = 1;
        @(posedge clk); #1;
        o_ready = 0;
        check({tag, "_clr_valid"}, 48'(o_valid), 48'd0);
        check({tag, "_clr_ready"}, 48'(i_ready), 48'd1);
        check({tag, "_clr_sum"}, o_sum, 48'd0);
        check({tag, "_clr_count"}, 48'(o_count), 48'd0);
    endtask
    initial begin
`ifdef MAC_ACC_SAT_EN
        ovf_exp = 48'h7FFF_FFFF_FFFF;
`else
        ovf_exp = -(48'd130177 << 30);
`endif
        #12;
        check("rst_valid", 48'(o_valid), 48'd0);
        check("rst_ready", 48'(i_ready), 48'd0);
        check("rst_sum", o_sum, 48'd0);
        check("rst_count", 48'(o_count), 48'd0);
        @(negedge clk) rst = 0;
        #1 check("ready_pre_edge", 48'(i_ready), 48'd0);
        @(posedge clk); #1;
        check("ready_post_edge", 48'(i_ready), 48'd1);
        // basic group: 3 + 20 - 8 = 15, o_valid two cycles after last beat
        o_ready = 0;
        send(0, 0, 3, 0);
        send(0, 2, 5, 0);
        send(1, 1, 4, 1);
        check("lat_t1", 48'(o_valid), 48'd0);
        check("drain_ready", 48'(i_ready), 48'd0);
        @(posedge clk); #1;
        check("lat_t2", 48'(o_valid), 48'd1);
        get_result("basic", 48'd15, 8'd3);
        // backpressure: -(1 << 10) held for 5 cycles
        send(1, 10, 1, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 48'(o_valid), 48'd1);
            check("bp_ready", 48'(i_ready), 48'd0);
            check("bp_sum", o_sum, -48'd1024);
            @(posedge clk); #1;
        end
        get_result("bp", -48'd1024, 8'd1);
        // back-to-back single-beat groups
        send(0, 0, 7, 1);
        get_result("b2b_a", 48'd7, 8'd1);
        send(0, 0, 9, 1);
        get_result("b2b_b", 48'd9, 8'd1);
        // overflow: 129 * 1023 * 2^30
        for (int i = 0; i < 129; i++) send(0, 30, 1023, i == 128);
        get_result("ovf", ovf_exp, 8'd129);
        // count saturation
        for (int i = 0; i < 300; i++) send(0, 0, 1, i == 299);
        get_result("cnt_sat", 48'd300, 8'd255);
        // reset mid-group discards the partial sum
        send(0, 0, 1, 0);
        send(0, 0, 1, 0);
        rst = 1;
        #2;
        check("mid_rst_sum", o_sum, 48'd0);
        check("mid_rst_count", 48'(o_count), 48'd0);
        check("mid_rst_ready", 48'(i_ready), 48'd0);
        @(negedge clk) rst = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mid_rst_novalid", 48'(o_valid), 48'd0);
        end
        send(0, 0, 2, 1);
        get_result("post_rst", 48'd2, 8'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_product_accumulator.md
MAC_PRODUCT_ACCUMULATOR -- requirements
Module: mac_product_accumulator

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 i_valid  input  1  product beat valid.
REQ-004 i_ready  output  1  block can accept a product beat.
REQ-005 i_sign  input  1  product sign; 1 = negative.
REQ-006 i_exp  input  5  product exponent, unsigned 0..30.
REQ-007 i_mant  input  10  product mantissa, unsigned.
REQ-008 i_last  input  1  beat is the final term of the current group.
REQ-009 o_valid  output  1  group result valid.
REQ-010 o_ready  input  1  downstream accepts the result.
REQ-011 o_sum  output  48  group sum, two's complement.
REQ-012 o_count  output  8  number of terms in the group, saturating at 255.

Function
REQ-013 A beat SHALL be accepted in a cycle where i_valid and i_ready are both 1; no other cycle changes group state.
REQ-014 Term value SHALL be i_mant shifted left by i_exp, zero-extended to 48 bits, then negated when i_sign=1.
- i_exp 31 is out of range; the result is not checked.
REQ-015 Stage 1 SHALL register the signed term, i_last and a term-valid flag one cycle after acceptance.
REQ-016 Stage 2 SHALL add the registered term into a 48-bit accumulator; i_mant=0 terms still count.
REQ-017 The FSM SHALL have three states:
- ACC: i_ready=1.
- DRAIN: last beat in stage 1; i_ready=0.
- HOLD: result presented; o_valid=1, i_ready=0.
REQ-018 Transitions:
- ACC->DRAIN on acceptance of a beat with i_last=1.
- DRAIN->HOLD next cycle, after the last term is accumulated.
- HOLD->ACC in the cycle o_valid and o_ready are both 1.
REQ-019 Latency: a last beat accepted in cycle T SHALL produce o_valid=1 at cycle T+2.
REQ-020 o_sum and o_count SHALL hold stable while o_valid=1 and o_ready=0.
REQ-021 On the HOLD->ACC handshake, accumulator and count SHALL clear; the next beat is accepted no earlier than the following cycle.
REQ-022 o_count SHALL increment once per accepted beat and stick at 255.
REQ-023 A single-beat group (first beat has i_last=1) SHALL produce o_count=1 and o_sum equal to that term.
REQ-024 When i_valid=0 in ACC, no term is added and state is unchanged; input gaps of any length are allowed.
REQ-025 o_sum SHALL be driven directly from the accumulator register, with no combinational path from i_* to o_*.

Reset
REQ-026 While rst=1, asynchronously:
- state=ACC, accumulator=0, count=0, stage-1 valid=0;
- o_valid=0, i_ready=0, o_sum=0, o_count=0.
REQ-027 After rst falls, i_ready SHALL be 1 from the first rising clk edge onward.
REQ-028 Reset asserted mid-group or in HOLD SHALL discard the partial group; no result is emitted for it.

Configuration
REQ-029 Macro MAC_ACC_SAT_EN selects the overflow behaviour of the accumulator.
- Defined: the accumulator SHALL saturate at +(2^47-1) or -2^47.
- Not defined: the accumulator SHALL wrap modulo 2^48.
REQ-030 With MAC_ACC_SAT_EN, once the accumulator saturates it SHALL stay at the rail until the group ends, and clear normally on the HOLD->ACC handshake.

Verification
REQ-031 Basic group: beats (0,0,3), (0,2,5), (1,1,4, last) back-to-back, o_ready=1 -> o_sum=15, o_count=3, o_valid exactly 2 cycles after the last beat.
REQ-032 Backpressure: single beat (1,10,1, last), o_ready=0 for 5 cycles -> o_sum=-1024 held stable with o_valid=1 and i_ready=0; completes when o_ready rises.
REQ-033 Back-to-back groups: two 1-beat groups (0,0,7,last) then (0,0,9,last) -> results 7 then 9; the accumulator clears between them.
REQ-034 Overflow: 129 beats of (0,30,1023), last on the 129th ->
- with MAC_ACC_SAT_EN: o_sum = 2^47-1;
- without it: o_sum = -130177*2^30;
- o_count=129 in both cases.
REQ-035 Count saturation: 300 beats of (0,0,1) -> o_sum=300, o_count=255.
REQ-036 Reset mid-group: 2 beats accepted, then rst pulsed -> o_valid stays 0; the next group (0,0,2,last) -> o_sum=2, o_count=1.
